// File: rtl/aes_pkg.sv
// aes_pkg: shared types and widths for the AES mode engine
package aes_pkg;
  localparam int BLK_W = 128;
  typedef enum logic [1:0] {M_ECB = 2'b00, M_CBC = 2'b01, M_CTR = 2'b10, M_RSV = 2'b11} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_OUT} state_e;
endpackage

// File: rtl/aes_mode_engine.sv
// aes_mode_engine: ECB/CBC/CTR block-mode controller driving one external AES core
// Ports: clk_i/rstn_i clock and async active-low reset; start_i/abort_i session control;
//   mode_i/dir_i/key_i/iv_i session setup; in_* input stream; out_* output stream;
//   core_* request/ack port to the AES core; busy_o/done_o/err_o/blk_cnt_o status.
module aes_mode_engine
  import aes_pkg::*;
#(
  parameter int KEY_W   = 128,
  parameter int CTR_W   = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [BLK_W-1:0] iv_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [BLK_W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [BLK_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             core_req_o,
  output logic             core_dir_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_din_o,
  input  logic             core_ack_i,
  input  logic [BLK_W-1:0] core_dout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  // shifting by the full width yields zero, so CTR_W == BLK_W gives an all-ones mask
  localparam logic [BLK_W-1:0] CTR_MASK = (BLK_W'(1) << CTR_W) - BLK_W'(1);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic dir_q, dir_d, last_q, last_d, done_q, done_d, err_q, err_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] chain_q, chain_d, ctr_q, ctr_d, data_q, data_d, out_q, out_d;
  logic [BLK_W-1:0] din, res, ctr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  assign din = mode_q == M_CTR ? ctr_q : (mode_q == M_CBC && !dir_q) ? data_q ^ chain_q : data_q;
  assign res = mode_q == M_CTR ? core_dout_i ^ data_q : (mode_q == M_CBC && dir_q) ? core_dout_i ^ chain_q : core_dout_i;
  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + BLK_W'(1)) & CTR_MASK);
  assign in_rdy_o = state_q == S_LOAD;
  assign out_vld_o = state_q == S_OUT;
  assign out_last_o = out_vld_o & last_q;
  assign out_data_o = out_q;
  assign core_req_o = state_q == S_REQ;
  assign core_dir_o = mode_q == M_CTR ? 1'b0 : dir_q;
  assign core_key_o = key_q;
  assign core_din_o = din;
  assign busy_o = state_q != S_IDLE;
  assign done_o = done_q;
  assign err_o = err_q;
  assign blk_cnt_o = cnt_q;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    dir_d = dir_q;
    key_d = key_q;
    chain_d = chain_q;
    ctr_d = ctr_q;
    data_d = data_q;
    last_d = last_q;
    out_d = out_q;
    cnt_d = cnt_q;
    err_d = err_q;
    wd_d = wd_q;
    done_d = 1'b0;
    if (abort_i) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_LOAD;
        key_d = key_i;
        mode_d = mode_e'(mode_i) == M_RSV ? M_ECB : mode_e'(mode_i);
        dir_d = dir_i;
        chain_d = iv_i;
        ctr_d = iv_i;
        cnt_d = '0;
        err_d = mode_e'(mode_i) == M_RSV;
      end
      S_LOAD: if (in_vld_i) begin
        state_d = S_REQ;
        data_d = in_data_i;
        last_d = in_last_i;
      end
      S_REQ: begin
        state_d = S_WAIT;
        wd_d = WD_W'(1);
      end
      S_WAIT: if (core_ack_i) begin
        state_d = S_OUT;
        out_d = res;
        chain_d = mode_q == M_CBC ? (dir_q ? data_q : core_dout_i) : chain_q;
        ctr_d = mode_q == M_CTR ? ctr_inc : ctr_q;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        err_d = 1'b1;
      end else wd_d = wd_q + WD_W'(1);
      S_OUT: if (out_rdy_i) begin
        state_d = last_q ? S_IDLE : S_LOAD;
        cnt_d = cnt_q + CNT_W'(1);
        done_d = last_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      mode_q <= M_ECB;
      dir_q <= 1'b0;
      key_q <= '0;
      chain_q <= '0;
      ctr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      out_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      wd_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      dir_q <= dir_d;
      key_q <= key_d;
      chain_q <= chain_d;
      ctr_q <= ctr_d;
      data_q <= data_d;
      last_q <= last_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      wd_q <= wd_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_aes_mode_engine.sv
// tb_aes_mode_engine: directed bench with an AES reference core and mode-level scoreboard
module tb_aes_mode_engine;
  logic clk_i = 0, rstn_i, start_i, abort_i, dir_i, in_vld_i, in_last_i, out_rdy_i, core_ack_i;
  logic [1:0] mode_i;
  logic [127:0] key_i, iv_i, in_data_i, core_dout_i;
  logic in_rdy_o, out_vld_o, out_last_o, core_req_o, core_dir_o, busy_o, done_o, err_o;
  logic [127:0] out_data_o, core_key_o, core_din_o;
  logic [15:0] blk_cnt_o;
  int n_pass = 0, n_tot = 0, n_done = 0, n_req = 0, n_vld = 0, cyc = 0;
  bit core_en, abort_on_ack;
  int core_lat;
  logic [127:0] got_q[$], din_q[$];
  logic [128:0] exp_q[$];
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  aes_mode_engine dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .dir_i(dir_i), .key_i(key_i), .iv_i(iv_i), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
    .in_data_i(in_data_i), .in_last_i(in_last_i), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .core_req_o(core_req_o),
    .core_dir_o(core_dir_o), .core_key_o(core_key_o), .core_din_o(core_din_o),
    .core_ack_i(core_ack_i), .core_dout_i(core_dout_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .blk_cnt_o(blk_cnt_o));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  // reference AES-128 built from GF(2^8) arithmetic
  logic [7:0] sb[256], isb[256];
  typedef logic [10:0][127:0] rks_t;
  typedef logic [0:15][7:0] st_t;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  initial begin : sbox_gen
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  end
  function automatic rks_t expand(input logic [127:0] key);
    logic [43:0][31:0] w;
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    rks_t k;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return k;
  endfunction
  function automatic st_t sub(input st_t s, input bit inv);
    st_t o;
    for (int i = 0; i < 16; i++) o[i] = inv ? isb[s[i]] : sb[s[i]];
    return o;
  endfunction
  function automatic st_t shr(input st_t s, input bit inv);
    st_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[r+4*c] = s[r + 4*((inv ? c - r + 4 : c + r) % 4)];
    return o;
  endfunction
  function automatic st_t mix(input st_t s, input bit inv);
    st_t o;
    logic [0:3][7:0] cf;
    cf = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = 0;
        for (int j = 0; j < 4; j++) o[4*c+r] ^= gm(s[4*c+j], cf[(j - r + 4) % 4]);
      end
    return o;
  endfunction
  function automatic logic [127:0] aes(input logic [127:0] key, input logic [127:0] d, input bit inv);
    rks_t k = expand(key);
    st_t s;
    if (!inv) begin
      s = d ^ k[0];
      for (int r = 1; r < 10; r++) s = mix(shr(sub(s, 0), 0), 0) ^ k[r];
      return shr(sub(s, 0), 0) ^ k[10];
    end
    s = d ^ k[10];
    for (int r = 9; r > 0; r--) s = mix(sub(shr(s, 1), 1) ^ k[r], 1);
    return sub(shr(s, 1), 1) ^ k[0];
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  function automatic logic [127:0] gq(input int i);
    return got_q.size() > i ? got_q[i] : '1;
  endfunction
  // external core: captures the request, answers after core_lat cycles
  initial begin : core_model
    logic [127:0] d, k;
    logic dr;
    core_ack_i = 0; core_dout_i = 0; abort_i = 0;
    forever begin
      @(negedge clk_i);
      if (core_req_o) begin
        n_req++;
        din_q.push_back(core_din_o);
        if (core_en) begin
          d = core_din_o; dr = core_dir_o; k = core_key_o;
          repeat (core_lat) @(posedge clk_i);
          #1 core_ack_i = 1; core_dout_i = aes(k, d, dr);
          if (abort_on_ack) abort_i = 1;
          @(posedge clk_i);
          #1 core_ack_i = 0; core_dout_i = 0; abort_i = 0;
        end
      end
    end
  end
  // mode-level scoreboard and per-cycle compare
  initial begin : compare
    logic [1:0] m_mode;
    logic m_dir, m_done;
    logic [127:0] m_key, m_chain, m_ctr, o;
    logic [128:0] e;
    logic [15:0] m_cnt;
    m_cnt = 0; m_done = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        exp_q.delete(); m_cnt = 0; m_done = 0;
      end else begin
        chk("done_o", done_o, m_done);
        chk("blk_cnt_o", blk_cnt_o, m_cnt);
        if (done_o) n_done++;
        if (out_vld_o) n_vld++;
        m_done = 0;
        if (abort_i) exp_q.delete();
        else begin
          if (start_i && !busy_o) begin
            m_mode = mode_i == 2'b11 ? 2'b00 : mode_i;
            m_dir = dir_i; m_key = key_i; m_chain = iv_i; m_ctr = iv_i; m_cnt = 0;
            exp_q.delete();
          end
          if (in_vld_i && in_rdy_o) begin
            if (m_mode == 2'b00) o = aes(m_key, in_data_i, m_dir);
            else if (m_mode == 2'b01 && !m_dir) begin
              o = aes(m_key, in_data_i ^ m_chain, 0);
              m_chain = o;
            end else if (m_mode == 2'b01) begin
              o = aes(m_key, in_data_i, 1) ^ m_chain;
              m_chain = in_data_i;
            end else begin
              o = aes(m_key, m_ctr, 0) ^ in_data_i;
              m_ctr[31:0] = m_ctr[31:0] + 32'd1;
            end
            exp_q.push_back({in_last_i, o});
          end
          if (out_vld_o && out_rdy_i) begin
            if (exp_q.size() == 0) begin
              n_tot++;
              $display("FAIL unexpected_out: got %h expected no output", out_data_o);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", out_data_o, e[127:0]);
              chk("out_last", out_last_o, e[128]);
              m_done = e[128];
            end
            got_q.push_back(out_data_o);
            m_cnt++;
          end
        end
      end
    end
  end
  task automatic start_s(input logic [1:0] m, input logic d, input logic [127:0] iv);
    mode_i = m; dir_i = d; iv_i = iv; key_i = KEY; start_i = 1;
    got_q.delete();
    @(posedge clk_i);
    #1 start_i = 0;
  endtask
  task automatic send(input logic [127:0] d, input logic l);
    int n = 0;
    in_vld_i = 1; in_data_i = d; in_last_i = l;
    while (!in_rdy_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) begin
      n_tot++;
      $display("FAIL send_timeout: got in_rdy_o=0 expected 1 within 300 cycles");
    end
    @(posedge clk_i);
    #1 in_vld_i = 0;
  endtask
  task automatic wait_sig(input string nm, input int which);
    int n = 0;
    while (n < 300 && (which == 0 ? busy_o : which == 1 ? !core_req_o : which == 2 ? !err_o : !out_vld_o)) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) begin
      n_tot++;
      $display("FAIL %s: condition not reached within 300 cycles", nm);
    end
  endtask
  task automatic wait_idle();
    wait_sig("wait_idle", 0);
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end
  initial begin : main
    logic [127:0] c[3], p[3], hold;
    int d0, r0, v0, rc, ec;
    p[0] = PT; p[1] = 128'h0123456789abcdeffedcba9876543210; p[2] = 128'hdeadbeefcafef00d01020304a5a5a5a5;
    rstn_i = 0; start_i = 0; mode_i = 0; dir_i = 0; key_i = 0; iv_i = 0;
    in_vld_i = 0; in_data_i = 0; in_last_i = 0; out_rdy_i = 1;
    core_en = 1; core_lat = 1; abort_on_ack = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ctl", {in_rdy_o, out_vld_o, out_last_o, core_req_o, core_dir_o, busy_o, done_o, err_o, blk_cnt_o}, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_core_key", core_key_o, 0);
    chk("rst_core_din", core_din_o, 0);
    chk("model_enc_vec", aes(KEY, PT, 0), CT);
    chk("model_dec_vec", aes(KEY, CT, 1), PT);
    rstn_i = 1;
    @(posedge clk_i);
    #1;
    d0 = n_done;
    start_s(2'b00, 0, 0);
    send(PT, 1);
    wait_idle();
    chk("ecb_enc", gq(0), CT);
    chk("ecb_enc_done", n_done - d0, 1);
    start_s(2'b00, 1, 0);
    send(CT, 1);
    wait_idle();
    chk("ecb_dec", gq(0), PT);
    start_s(2'b11, 0, 0);
    chk("rsv_err", err_o, 1);
    send(PT, 1);
    wait_idle();
    chk("rsv_as_ecb", gq(0), CT);
    d0 = n_done;
    start_s(2'b01, 0, KEY);
    chk("start_clears_err", err_o, 0);
    for (int i = 0; i < 3; i++) send(p[i], i == 2);
    wait_idle();
    for (int i = 0; i < 3; i++) c[i] = gq(i);
    chk("cbc_enc_cnt", blk_cnt_o, 3);
    chk("cbc_enc_done", n_done - d0, 1);
    d0 = n_done;
    start_s(2'b01, 1, KEY);
    for (int i = 0; i < 3; i++) send(c[i], i == 2);
    wait_idle();
    for (int i = 0; i < 3; i++) chk("cbc_roundtrip", gq(i), p[i]);
    chk("cbc_dec_cnt", blk_cnt_o, 3);
    chk("cbc_dec_done", n_done - d0, 1);
    start_s(2'b10, 1, 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff);
    din_q.delete();
    send(p[0], 0);
    send(p[1], 1);
    wait_idle();
    chk("ctr_din0", din_q.size() > 0 ? din_q[0] : '1, 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff);
    chk("ctr_din1_wrap", din_q.size() > 1 ? din_q[1] : '1, 128'hf0f1f2f3f4f5f6f7f8f9fafb00000000);
    chk("ctr_cnt", blk_cnt_o, 2);
    start_s(2'b00, 0, 0);
    out_rdy_i = 0;
    send(PT, 0);
    wait_sig("bp_out_vld", 3);
    r0 = n_req;
    hold = out_data_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("bp_stable", out_data_o, hold);
      chk("bp_in_rdy", in_rdy_o, 0);
      chk("bp_out_vld", out_vld_o, 1);
    end
    chk("bp_no_req", n_req - r0, 0);
    chk("bp_data", hold, CT);
    @(posedge clk_i);
    #1 out_rdy_i = 1;
    send(PT, 1);
    wait_idle();
    chk("bp_cnt", blk_cnt_o, 2);
    core_en = 0;
    d0 = n_done;
    start_s(2'b00, 0, 0);
    send(PT, 1);
    wait_sig("to_req", 1);
    rc = cyc;
    wait_sig("to_err", 2);
    ec = cyc;
    chk("to_cycles", ec - rc, 64);
    chk("to_busy", busy_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("to_err_sticky", err_o, 1);
    chk("to_no_done", n_done - d0, 0);
    core_en = 1;
    abort_on_ack = 1;
    d0 = n_done; v0 = n_vld;
    start_s(2'b00, 0, 0);
    send(PT, 1);
    wait_idle();
    repeat (3) @(posedge clk_i);
    #1 abort_on_ack = 0;
    chk("abort_no_vld", n_vld - v0, 0);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_busy", busy_o, 0);
    core_lat = 8;
    v0 = n_vld;
    start_s(2'b00, 0, 0);
    send(PT, 1);
    wait_sig("rst_req", 1);
    repeat (2) @(negedge clk_i);
    #2 rstn_i = 0;
    #1;
    chk("midrst_ctl", {in_rdy_o, out_vld_o, out_last_o, core_req_o, core_dir_o, busy_o, done_o, err_o, blk_cnt_o}, 0);
    chk("midrst_out_data", out_data_o, 0);
    chk("midrst_core_key", core_key_o, 0);
    chk("midrst_core_din", core_din_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1;
    repeat (12) @(posedge clk_i);
    #1;
    chk("late_ack_busy", busy_o, 0);
    chk("late_ack_no_vld", n_vld - v0, 0);
    core_lat = 1;
    start_s(2'b00, 0, 0);
    send(PT, 1);
    wait_idle();
    chk("recover_ecb", gq(0), CT);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
